// File: rtl/wb_stage_pkg.sv
// Shared pcore interface definitions for the writeback stage: widths,
// load-op encoding, writeback FSM states and a small rd-write helper.
package wb_stage_pkg;

   localparam int XLEN      = 32;
   localparam int RF_AWIDTH = 5;

   typedef enum logic [2:0] {
      LD_B  = 3'b000,
      LD_H  = 3'b001,
      LD_W  = 3'b010,
      LD_BU = 3'b100,
      LD_HU = 3'b101
   } ld_ops_e;

   typedef enum logic {
      WB_IDLE    = 1'b0,
      WB_LD_WAIT = 1'b1
   } wb_state_e;

   // x0 is hardwired to zero, so a write to it never reaches the register file.
   function automatic logic rd_writes(input logic                 wr_req,
                                      input logic [RF_AWIDTH-1:0] rd);
      return wr_req && (rd != '0);
   endfunction

endpackage

// File: rtl/wb_stage_load_extend.sv
// Combinational load data extraction: picks the byte/half lane addressed by
// the low address bits and sign- or zero-extends it to XLEN.
module load_extend
   import wb_stage_pkg::*;
(
   input  logic [XLEN-1:0] data_i,
   input  logic [2:0]      ld_ops_i,
   input  logic [1:0]      addr_lsb_i,
   output logic [XLEN-1:0] data_o
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane[gi] = data_i[8*gi +: 8];
   end

   // Halfword lane is chosen by bit 1 only; bit 0 is ignored for halves.
   assign byte_sel = lane[addr_lsb_i];
   assign half_sel = addr_lsb_i[1] ? data_i[31:16] : data_i[15:0];

   always_comb begin
      data_o = '0;
      case (ld_ops_i)
         LD_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
         LD_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
         LD_W:    data_o = data_i;
         LD_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
         LD_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires ALU results in one cycle and holds execute while a
// load is outstanding, then writes the extended LSU response to the register file.
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 exe2wb_valid_i,
   input  logic                 exe2wb_rd_wr_req_i,
   input  logic [RF_AWIDTH-1:0] exe2wb_rd_addr_i,
   input  logic [XLEN-1:0]      exe2wb_alu_result_i,
   input  logic                 exe2wb_ld_req_i,
   input  logic [2:0]           exe2wb_ld_ops_i,
   input  logic [1:0]           exe2wb_addr_lsb_i,
   input  logic                 lsu2wb_rsp_valid_i,
   input  logic [XLEN-1:0]      lsu2wb_rsp_data_i,
   output logic                 wb2exe_stall_o,
   output logic                 wb2rf_rd_wr_req_o,
   output logic [RF_AWIDTH-1:0] wb2rf_rd_addr_o,
   output logic [XLEN-1:0]      wb2rf_rd_data_o,
   output logic                 wb_rsp_err_o
);

   wb_state_e            state_q, state_d;
   logic                 wr_req_q, wr_req_d;
   logic [RF_AWIDTH-1:0] addr_q, addr_d;
   logic [XLEN-1:0]      data_q, data_d;
   logic                 err_q, err_d;

   logic                 cap_wr_q, cap_wr_d;
   logic [RF_AWIDTH-1:0] cap_rd_q, cap_rd_d;
   logic [2:0]           cap_ops_q, cap_ops_d;
   logic [1:0]           cap_lsb_q, cap_lsb_d;

   logic [XLEN-1:0]      ld_data;

   load_extend u_load_extend (
      .data_i     (lsu2wb_rsp_data_i),
      .ld_ops_i   (cap_ops_q),
      .addr_lsb_i (cap_lsb_q),
      .data_o     (ld_data)
   );

   always_comb begin
      state_d   = state_q;
      wr_req_d  = 1'b0;
      addr_d    = addr_q;
      data_d    = data_q;
      err_d     = 1'b0;
      cap_wr_d  = cap_wr_q;
      cap_rd_d  = cap_rd_q;
      cap_ops_d = cap_ops_q;
      cap_lsb_d = cap_lsb_q;

      case (state_q)
         WB_IDLE: begin
            // No load is outstanding, so any LSU response here is spurious.
            err_d = lsu2wb_rsp_valid_i;
            if (exe2wb_valid_i) begin
               if (exe2wb_ld_req_i) begin
                  cap_wr_d  = exe2wb_rd_wr_req_i;
                  cap_rd_d  = exe2wb_rd_addr_i;
                  cap_ops_d = exe2wb_ld_ops_i;
                  cap_lsb_d = exe2wb_addr_lsb_i;
                  state_d   = WB_LD_WAIT;
               end else begin
                  wr_req_d = rd_writes(exe2wb_rd_wr_req_i, exe2wb_rd_addr_i);
                  addr_d   = exe2wb_rd_addr_i;
                  data_d   = exe2wb_alu_result_i;
               end
            end
         end
         WB_LD_WAIT: begin
            if (lsu2wb_rsp_valid_i) begin
               wr_req_d = rd_writes(cap_wr_q, cap_rd_q);
               addr_d   = cap_rd_q;
               data_d   = ld_data;
               state_d  = WB_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= WB_IDLE;
         wr_req_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         err_q     <= 1'b0;
         cap_wr_q  <= 1'b0;
         cap_rd_q  <= '0;
         cap_ops_q <= '0;
         cap_lsb_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_req_q  <= wr_req_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         err_q     <= err_d;
         cap_wr_q  <= cap_wr_d;
         cap_rd_q  <= cap_rd_d;
         cap_ops_q <= cap_ops_d;
         cap_lsb_q <= cap_lsb_d;
      end
   end

   assign wb2exe_stall_o    = (state_q == WB_LD_WAIT);
   assign wb2rf_rd_wr_req_o = wr_req_q;
   assign wb2rf_rd_addr_o   = addr_q;
   assign wb2rf_rd_data_o   = data_q;
   assign wb_rsp_err_o      = err_q;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters: none; widths come from `XLEN` (32) and `RF_AWIDTH` (5) in the shared defines.
REQ-002 clk  in  1  clock; all state updates on posedge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 exe2wb_valid_i  in  1  execute result valid this cycle.
REQ-005 exe2wb_rd_wr_req_i  in  1  instruction writes rd.
REQ-006 exe2wb_rd_addr_i  in  RF_AWIDTH  destination register.
REQ-007 exe2wb_alu_result_i  in  XLEN  ALU/CSR result for non-load instructions.
REQ-008 exe2wb_ld_req_i  in  1  instruction is a load; data comes from LSU.
REQ-009 exe2wb_ld_ops_i  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-010 exe2wb_addr_lsb_i  in  2  load address bits [1:0].
REQ-011 lsu2wb_rsp_valid_i  in  1  load response valid (single-cycle pulse).
REQ-012 lsu2wb_rsp_data_i  in  XLEN  raw aligned memory word.
REQ-013 wb2exe_stall_o  out  1  holds execute while a load is outstanding.
REQ-014 wb2rf_rd_wr_req_o  out  1  register file write request.
REQ-015 wb2rf_rd_addr_o  out  RF_AWIDTH  register file write address.
REQ-016 wb2rf_rd_data_o  out  XLEN  register file write data.
REQ-017 wb_rsp_err_o  out  1  one-cycle pulse on an unexpected LSU response.

Function
REQ-018 FSM states: IDLE, LD_WAIT.
REQ-019 IDLE, exe2wb_valid_i=1, ld_req=0: on the next posedge, register wr_req = rd_wr_req & (rd_addr!=0), addr = rd_addr, data = alu_result; latency 1 cycle.
REQ-020 IDLE, exe2wb_valid_i=1, ld_req=1: capture rd_wr_req, rd_addr, ld_ops, addr_lsb; go to LD_WAIT; wr_req=0 that cycle.
REQ-021 LD_WAIT: wb2exe_stall_o=1 (decoded from registered state); exe inputs ignored.
REQ-022 LD_WAIT, rsp_valid=1: next posedge writes extended data with wr_req = captured rd_wr_req & (captured rd!=0); return to IDLE; stall drops the same cycle.
REQ-023 A single-cycle pulse is a one-cycle assertion; wb2rf_rd_wr_req_o is a one-cycle pulse per retired instruction and 0 when no instruction retires.
REQ-024 Extension: byte lane = addr_lsb; half lane = addr_lsb[1] (addr_lsb[0] ignored); LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
REQ-025 Any other ld_ops value writes zero data with the captured wr_req.
REQ-026 rsp_valid in IDLE: ignored, no write, wb_rsp_err_o pulses 1 cycle.
REQ-027 exe_valid=0 in IDLE: wr_req=0; addr/data hold their previous values.
REQ-028 The register file write lands on the following negedge, so decode reads in the next cycle see the new value; this block adds no forwarding.

Reset
REQ-029 With rst_n=0 at a posedge: state=IDLE, stall=0, wr_req=0, addr=0, data=0, err=0, captured load fields=0.
REQ-030 Reset in LD_WAIT abandons the load; a response arriving after reset is treated as unexpected (REQ-026).

Structure
REQ-031 The load-op encoding enum and the wb FSM state typedef live in the shared pcore interface defines package.
REQ-032 Load extraction/extension is a combinational sub-module, load_extend (inputs: data, ld_ops, addr_lsb; output: XLEN data).
REQ-033 The block targets 120-400 lines of RTL; all outputs are registered except stall, which is decoded from the state register.

Verification
REQ-034 ALU op rd=5, result 0x1234_5678 -> next cycle wr_req=1, addr=5, data=0x1234_5678, stall=0.
REQ-035 LB, addr_lsb=3, rsp 0x80FF_FF01 -> stall=1 until rsp; one cycle after rsp: data=0xFFFF_FF80, wr_req=1.
REQ-036 LHU, addr_lsb=2, rsp 0xBEEF_0000 -> data=0x0000_BEEF; LH, same inputs -> data=0xFFFF_BEEF.
REQ-037 ALU op rd=0, result 0xDEAD_BEEF -> wr_req stays 0; rsp_valid in IDLE -> err pulses, no write.
REQ-038 Load issued, rst_n=0 in LD_WAIT, then rsp arrives -> stall=0, no write, err pulses.
REQ-039 Back-to-back ALU ops rd=1,2,3 -> three consecutive write pulses in order, no stall.
